aes_inv_cipher: RTL and testbench

//  Iterative AES-128 decryptor: the inverse of the encryption core. Takes ciphertext + cipher key,

---
 rtl/aes_pkg.sv | 82 ++++++++
 rtl/aes_inv_round.sv | 47 ++++
 rtl/aes_inv_cipher.sv | 162 ++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants for the decrypt datapath: byte substitution tables, round constants,
// FSM state encodings and GF(2^8) helpers (reduction polynomial 0x11B).
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int NB_RK      = AES_ROUNDS + 1;
  localparam int RND_W      = $clog2(NB_RK);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_KEXP  = 3'd1;
  localparam logic [2:0] ST_INIT  = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;

  // Element 0 is the leftmost byte, so a table lookup is simply TABLE[byte].
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [0:AES_ROUNDS][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless i_last selects the final-round form.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [127:0] sub_bytes;
  logic [127:0] ark;
  logic [127:0] mix;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = col;
    return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
  endfunction

  // Byte (col c, row r) sits at bit 127-8*(4c+r); row r is rotated right by r columns.
  always_comb begin
    sub_bytes = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_bytes[127 - 8*(4*c + r) -: 8] =
          INV_SBOX[i_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]];
      end
    end
  end

  assign ark = sub_bytes ^ i_round_key;

  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      mix[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
    end
  end

  assign o_state = i_last ? ark : mix;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor: forward key expansion into an 11-entry round-key store, then one
// inverse round per clock. Define AES_DEC_KEY_CACHE_EN to skip expansion when the key repeats.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NB_ROUNDS = 10,
  parameter bit OUT_HOLD  = 1'b1
) (
  input  logic         i_AES_DEC_clk,
  input  logic         i_AES_DEC_rst,
  input  logic [127:0] i_AES_DEC_cipher_text,
  input  logic [127:0] i_AES_DEC_key_in,
  input  logic         i_AES_DEC_valid,
  output logic         o_AES_DEC_ready,
  output logic [127:0] o_AES_DEC_data_decrypted,
  output logic         o_AES_DEC_valid
);

  if (NB_ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes_inv_cipher: only NB_ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [RND_W-1:0] RND_ONE   = RND_W'(1);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(AES_ROUNDS);
  localparam logic [RND_W-1:0] RND_START = RND_W'(AES_ROUNDS - 1);

  // blk_q is the AES cipher state being decrypted, distinct from the FSM state.
  logic [2:0]              state_q, state_d;
  logic [RND_W-1:0]        rnd_q, rnd_d;
  logic [127:0]            blk_q, blk_d;
  logic [NB_RK-1:0][127:0] rk_q, rk_d;
  logic [127:0]            data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    accept;
  logic [127:0]            kx_prev;
  logic [127:0]            kx_next;
  logic [31:0]             kx_temp;
  logic [127:0]            round_out;
  logic                    round_last;
`ifdef AES_DEC_KEY_CACHE_EN
  logic                    cache_vld_q, cache_vld_d;
  logic                    key_hit;
`endif

  assign o_AES_DEC_ready = (state_q == ST_IDLE);
  assign accept          = i_AES_DEC_valid && o_AES_DEC_ready;
  assign round_last      = (state_q == ST_FINAL);

`ifdef AES_DEC_KEY_CACHE_EN
  assign key_hit = cache_vld_q && (i_AES_DEC_key_in == rk_q[0]);
`endif

  // One AES-128 key schedule step: round key rnd from round key rnd-1.
  always_comb begin
    kx_prev          = rk_q[rnd_q - RND_ONE];
    kx_temp          = sub_word(rot_word(kx_prev[31:0])) ^ {RCON[rnd_q], 24'h000000};
    kx_next[127:96]  = kx_prev[127:96] ^ kx_temp;
    kx_next[95:64]   = kx_prev[95:64]  ^ kx_next[127:96];
    kx_next[63:32]   = kx_prev[63:32]  ^ kx_next[95:64];
    kx_next[31:0]    = kx_prev[31:0]   ^ kx_next[63:32];
  end

  // FINAL reaches here with rnd_q == 0, so rk_q[rnd_q] is the right key in both uses.
  aes_inv_round u_round (
    .i_state     (blk_q),
    .i_round_key (rk_q[rnd_q]),
    .i_last      (round_last),
    .o_state     (round_out)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rk_d[0] = i_AES_DEC_key_in;
          blk_d   = i_AES_DEC_cipher_text;
          rnd_d   = RND_ONE;
          state_d = ST_KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          if (key_hit) begin
            state_d = ST_INIT;
          end else begin
            cache_vld_d = 1'b0;
          end
`endif
        end
      end
      ST_KEXP: begin
        rk_d[rnd_q] = kx_next;
        rnd_d       = rnd_q + RND_ONE;
        if (rnd_q == RND_LAST) begin
          state_d = ST_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_vld_d = 1'b1;
`endif
        end
      end
      ST_INIT: begin
        blk_d   = blk_q ^ rk_q[NB_RK-1];
        rnd_d   = RND_START;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        blk_d = round_out;
        rnd_d = rnd_q - RND_ONE;
        if (rnd_q == RND_ONE) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        data_d  = round_out;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_AES_DEC_clk) begin
    if (i_AES_DEC_rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      rk_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge i_AES_DEC_clk) begin
    if (i_AES_DEC_rst) begin
      cache_vld_q <= 1'b0;
    end else begin
      cache_vld_q <= cache_vld_d;
    end
  end
`endif

  assign o_AES_DEC_valid = valid_q;

  if (OUT_HOLD) begin : g_out_hold
    assign o_AES_DEC_data_decrypted = data_q;
  end else begin : g_out_gated
    assign o_AES_DEC_data_decrypted = valid_q ? data_q : '0;
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher: known-answer vectors plus back-to-back, busy, abort and
// key-reuse sequences, with a gated-output instance and a held-output instance side by side.
module tb_aes_inv_cipher;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ct_in;
  logic [127:0] key_in;
  logic         in_valid;
  logic         ready, ready_h;
  logic [127:0] data, data_h;
  logic         valid, valid_h;

  int           total = 0;
  int           bad   = 0;
  bit           model_cache_vld;
  logic [127:0] model_key;
  logic [127:0] prev_pt;
  vec_t         vecs[4];

  always #5 clk = ~clk;

  aes_inv_cipher #(.NB_ROUNDS(10), .OUT_HOLD(1'b0)) dut (
    .i_AES_DEC_clk            (clk),
    .i_AES_DEC_rst            (rst),
    .i_AES_DEC_cipher_text    (ct_in),
    .i_AES_DEC_key_in         (key_in),
    .i_AES_DEC_valid          (in_valid),
    .o_AES_DEC_ready          (ready),
    .o_AES_DEC_data_decrypted (data),
    .o_AES_DEC_valid          (valid)
  );

  aes_inv_cipher #(.NB_ROUNDS(10), .OUT_HOLD(1'b1)) dut_hold (
    .i_AES_DEC_clk            (clk),
    .i_AES_DEC_rst            (rst),
    .i_AES_DEC_cipher_text    (ct_in),
    .i_AES_DEC_key_in         (key_in),
    .i_AES_DEC_valid          (in_valid),
    .o_AES_DEC_ready          (ready_h),
    .o_AES_DEC_data_decrypted (data_h),
    .o_AES_DEC_valid          (valid_h)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst             = 1'b0;
    model_cache_vld = 1'b0;
    prev_pt         = '0;
  endtask

  // Waits for ready, presents one request and returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] ct, input bit keep_valid);
    for (int i = 0; i < 60 && !ready; i++) @(negedge clk);
    checkOutput("ready before accept", 128'(ready), 128'(1));
    key_in   = key;
    ct_in    = ct;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Counts edges after the accept until o_valid, watching idle outputs on the way.
  task automatic waitResult(input int lat_exp, input bit scramble, output int lat,
                            output logic [127:0] pt, output logic [127:0] pt_h,
                            output bit zero_ok, output bit hold_ok, output bit busy_ok);
    lat = -1; pt = '0; pt_h = '0;
    zero_ok = 1'b1; hold_ok = 1'b1; busy_ok = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      if (valid_h !== valid || ready_h !== ready) hold_ok = 1'b0;
      if (valid) begin
        lat  = e;
        pt   = data;
        pt_h = data_h;
        break;
      end
      if (data !== '0) zero_ok = 1'b0;
      if (data_h !== prev_pt) hold_ok = 1'b0;
      if (ready) busy_ok = 1'b0;
      if (scramble) begin
        if (e < lat_exp - 1) begin
          in_valid = 1'($urandom_range(0, 1));
          key_in   = {$urandom, $urandom, $urandom, $urandom};
          ct_in    = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic runJob(input vec_t v, input bit keep_valid, input bit scramble, input string tag);
    int           lat_exp, lat;
    logic [127:0] pt, pt_h;
    bit           zero_ok, hold_ok, busy_ok, hit;
    hit     = CACHE_EN && model_cache_vld && (v.key == model_key);
    lat_exp = hit ? 11 : 21;
    applyStimulus(v.key, v.ct, keep_valid);
    waitResult(lat_exp, scramble, lat, pt, pt_h, zero_ok, hold_ok, busy_ok);
    checkOutput({tag, " latency"}, 128'(lat), 128'(lat_exp));
    checkOutput({tag, " plaintext"}, pt, v.pt);
    checkOutput({tag, " held plaintext"}, pt_h, v.pt);
    checkOutput({tag, " gated zero while busy"}, 128'(zero_ok), 128'(1));
    checkOutput({tag, " held value while busy"}, 128'(hold_ok), 128'(1));
    checkOutput({tag, " ready low while busy"}, 128'(busy_ok), 128'(1));
    if (!hit) begin
      model_cache_vld = 1'b1;
      model_key       = v.key;
    end
    prev_pt = v.pt;
    if (!keep_valid) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " valid pulse one cycle"}, 128'(valid), 128'(0));
      checkOutput({tag, " gated data after pulse"}, data, '0);
      checkOutput({tag, " held data after pulse"}, data_h, v.pt);
      checkOutput({tag, " ready after pulse"}, 128'(ready), 128'(1));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit reached expected test end");
    $fatal(1);
  end

  initial begin
    int stray;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{128'h00000000000000000000000000000000, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'h00000000000000000000000000000000};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};

    rst = 1'b1; in_valid = 1'b0; key_in = '0; ct_in = '0;
    doReset();
    $display("[TB] reset state");
    checkOutput("reset ready", 128'(ready), 128'(1));
    checkOutput("reset valid", 128'(valid), 128'(0));
    checkOutput("reset data", data, '0);
    checkOutput("reset held ready", 128'(ready_h), 128'(1));
    checkOutput("reset held valid", 128'(valid_h), 128'(0));
    checkOutput("reset held data", data_h, '0);

    $display("[TB] known-answer vectors");
    for (int i = 0; i < 4; i++) runJob(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    $display("[TB] back-to-back with valid held high");
    runJob(vecs[1], 1'b1, 1'b0, "b2b first");
    runJob(vecs[0], 1'b0, 1'b0, "b2b second");

    $display("[TB] inputs disturbed while busy");
    runJob(vecs[0], 1'b0, 1'b1, "busy");

    $display("[TB] reset in the middle of a job");
    applyStimulus(vecs[1].key, vecs[1].ct, 1'b0);
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort ready", 128'(ready), 128'(1));
    checkOutput("abort valid", 128'(valid), 128'(0));
    checkOutput("abort data", data, '0);
    checkOutput("abort held data", data_h, '0);
    model_cache_vld = 1'b0;
    prev_pt         = '0;
    stray = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid || valid_h) stray++;
    end
    checkOutput("abort stray valid", 128'(stray), 128'(0));
    runJob(vecs[0], 1'b0, 1'b0, "after abort");

    $display("[TB] key reuse");
    doReset();
    runJob(vecs[0], 1'b0, 1'b0, "reuse first");
    runJob(vecs[0], 1'b0, 1'b0, "reuse second");
    doReset();
    runJob(vecs[0], 1'b0, 1'b0, "reuse after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
